// File: rtl/if_id_pipe_if.sv
// Fetch-side bundle between the hazard unit, the instruction SRAM and the IF/ID register.
// master = environment (hazard unit + SRAM), slave = if_id_pipe.
interface if_id_pipe_if;
    logic        stall_pc;
    logic        stall_if_id;
    logic        flush_if_id;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    modport master (
        output stall_pc, stall_if_id, flush_if_id, redirect_valid, redirect_target,
        output inst_sram_rdata,
        input  inst_sram_en, inst_sram_addr, id_pc, id_inst, id_valid
    );

    modport slave (
        input  stall_pc, stall_if_id, flush_if_id, redirect_valid, redirect_target,
        input  inst_sram_rdata,
        output inst_sram_en, inst_sram_addr, id_pc, id_inst, id_valid
    );
endinterface

// File: rtl/if_id_pipe.sv
// PC register, synchronous instruction SRAM request stage and IF/ID pipeline register,
// with a one-entry hold buffer for stalls and a pending-redirect slot.
module if_id_pipe #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input logic          clk,
    input logic          resetn,
    if_id_pipe_if.slave  pipe
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_valid_q, req_valid_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;

    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        req_valid_d  = req_valid_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;

        if (!pipe.stall_pc) begin
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            // A live redirect at stall release wins over the queued one.
            if (pipe.redirect_valid) begin
                pc_d         = pipe.redirect_target;
                redir_pend_d = 1'b0;
            end else if (redir_pend_q) begin
                pc_d         = redir_tgt_q;
                redir_pend_d = 1'b0;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else if (pipe.redirect_valid) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = pipe.redirect_target;
        end
    end

    always_comb begin
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        id_valid_d   = id_valid_q;
        hold_valid_d = hold_valid_q;
        hold_inst_d  = hold_inst_q;

        if (pipe.flush_if_id) begin
            id_valid_d   = 1'b0;
            id_inst_d    = NOP_INST;
            id_pc_d      = req_pc_q;
            hold_valid_d = 1'b0;
        end else if (pipe.stall_if_id) begin
            // Only the first stall cycle sees req_pc's data; later reads are of pc_f.
            if (!hold_valid_q && req_valid_q) begin
                hold_valid_d = 1'b1;
                hold_inst_d  = pipe.inst_sram_rdata;
            end
        end else begin
            id_pc_d      = req_pc_q;
            id_inst_d    = hold_valid_q ? hold_inst_q : pipe.inst_sram_rdata;
            id_valid_d   = req_valid_q;
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'd0;
            req_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_inst_q  <= 32'd0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 32'd0;
            id_pc_q      <= 32'd0;
            id_inst_q    <= NOP_INST;
            id_valid_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            req_valid_q  <= req_valid_d;
            hold_valid_q <= hold_valid_d;
            hold_inst_q  <= hold_inst_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            id_pc_q      <= id_pc_d;
            id_inst_q    <= id_inst_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign pipe.inst_sram_en   = resetn;
    assign pipe.inst_sram_addr = pc_q;
    assign pipe.id_pc          = id_pc_q;
    assign pipe.id_inst        = id_inst_q;
    assign pipe.id_valid       = id_valid_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: directed scenarios followed by random stall/flush/redirect
// traffic, compared against a fetch-stream model where SRAM data is a pure function of address.
module tb_if_id_pipe;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clk;
    logic        resetn;
    logic [31:0] sram_key;
    int          checks;
    int          errors;

    if_id_pipe_if bus ();

    if_id_pipe #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .pipe   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: one-cycle read latency, word = address ^ key.
    always @(posedge clk) begin
        if (bus.inst_sram_en) bus.inst_sram_rdata <= bus.inst_sram_addr ^ sram_key;
    end

    always @(negedge clk) begin
        if (resetn) assert (!(bus.stall_if_id && !bus.stall_pc))
            else $error("illegal stall combination driven");
    end

    // Reference model state
    logic [31:0] m_pc, m_tgt, m_req_pc, m_id_pc, m_id_inst;
    logic        m_pend, m_req_v, m_id_v;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_pend = 1'b0; m_tgt = 32'd0;
        m_req_pc = 32'd0; m_req_v = 1'b0;
        m_id_pc = 32'd0; m_id_inst = NOP_INST; m_id_v = 1'b0;
    endtask

    // One clock edge of the fetch stream: ID takes the request slot, request takes the PC.
    task automatic model_step();
        if (bus.flush_if_id) begin
            m_id_v = 1'b0; m_id_inst = NOP_INST; m_id_pc = m_req_pc;
        end else if (!bus.stall_if_id) begin
            m_id_pc = m_req_pc; m_id_inst = m_req_pc ^ sram_key; m_id_v = m_req_v;
        end
        if (bus.stall_pc) begin
            if (bus.redirect_valid) begin
                m_pend = 1'b1; m_tgt = bus.redirect_target;
            end
        end else begin
            m_req_pc = m_pc; m_req_v = 1'b1;
            if (bus.redirect_valid) m_pc = bus.redirect_target;
            else if (m_pend) m_pc = m_tgt;
            else m_pc = m_pc + 32'd4;
            m_pend = 1'b0;
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic rv, input logic [31:0] rt);
        bus.stall_pc        = st;
        bus.stall_if_id     = st;
        bus.flush_if_id     = fl;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
    endtask

    task automatic compare_model();
        check_val("sram_en", 32'(bus.inst_sram_en), 32'd1);
        check_val("sram_addr", bus.inst_sram_addr, m_pc);
        check_val("id_valid", 32'(bus.id_valid), 32'(m_id_v));
        check_val("id_pc", bus.id_pc, m_id_pc);
        if (m_id_v) check_val("id_inst", bus.id_inst, m_id_inst);
    endtask

    task automatic cycle(input logic st, input logic fl, input logic rv, input logic [31:0] rt);
        drive(st, fl, rv, rt);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_en"}, 32'(bus.inst_sram_en), 32'd0);
        check_val({tag, "_addr"}, bus.inst_sram_addr, RESET_PC);
        check_val({tag, "_id_pc"}, bus.id_pc, 32'd0);
        check_val({tag, "_id_inst"}, bus.id_inst, NOP_INST);
        check_val({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
        check_val({tag, "_pend"}, 32'(dut.redir_pend_q), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sram_key = 32'd0;
        bus.inst_sram_rdata = 32'd0;
        resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check_reset("rst");
        resetn = 1'b1;

        // Straight-line fetch, SRAM returns the address
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t1_pc0", bus.id_pc, 32'hBFC0_0000);
        check_val("t1_inst0", bus.id_inst, 32'hBFC0_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t1_pc1", bus.id_pc, 32'hBFC0_0004);

        // Three-cycle stall with req_pc = BFC00008
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        check_val("t2_hold_pc", bus.id_pc, 32'hBFC0_0004);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t2_rel_pc", bus.id_pc, 32'hBFC0_0008);
        check_val("t2_rel_inst", bus.id_inst, 32'hBFC0_0008);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t2_next_inst", bus.id_inst, 32'hBFC0_000C);

        // Unstalled redirect: request-stage instructions still reach ID
        cycle(1'b0, 1'b0, 1'b1, 32'h8000_1000);
        check_val("t3_slot", bus.id_pc, 32'hBFC0_0010);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t3_tgt", bus.id_inst, 32'h8000_1000);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t3_tgt4", bus.id_inst, 32'h8000_1004);

        // Redirect queued during a stall, applied at release
        cycle(1'b1, 1'b0, 1'b1, 32'h8000_2000);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t4_pc", bus.inst_sram_addr, 32'h8000_2000);
        check_val("t4_pend", 32'(dut.redir_pend_q), 32'd0);

        // Flush together with stall drops the hold buffer
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check_val("t5_valid", 32'(bus.id_valid), 32'd0);
        check_val("t5_inst", bus.id_inst, NOP_INST);
        check_val("t5_hold", 32'(dut.hold_valid_q), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'd0);

        // Reset mid-stall with a pending redirect
        cycle(1'b1, 1'b0, 1'b1, 32'h8000_3000);
        check_val("t6_pend_set", 32'(dut.redir_pend_q), 32'd1);
        #2 resetn = 1'b0;
        #1 check_reset("t6_rst");
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        sram_key = 32'h1357_9BDF;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t6_restart", bus.id_pc, 32'hBFC0_0000);
        check_val("t6_inst", bus.id_inst, 32'hBFC0_0000 ^ 32'h1357_9BDF);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        st, fl, rv;
            logic [31:0] rt;
            st = ($urandom_range(0, 3) == 0);
            fl = !st && ($urandom_range(0, 9) == 0);
            rv = ($urandom_range(0, 6) == 0);
            rt = $urandom() & 32'hFFFF_FFFC;
            cycle(st, fl, rv, rt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
